// File: rtl/alu_disp_pkg.sv
// alu_disp_pkg: FSM states, seven-segment codes and BCD helpers for alu_result_display.
package alu_disp_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_LOAD = 2'd2,
        ST_ACK  = 2'd3
    } state_t;
    localparam int N_ITER = 9;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    function automatic logic [11:0] add3(input logic [11:0] b);
        logic [11:0] r;
        for (int i = 0; i < 3; i++)
            r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? b[i*4 +: 4] + 4'd3 : b[i*4 +: 4];
        return r;
    endfunction
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction
endpackage

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential 9-bit double-dabble; one add-3/shift step per clock.
// done is high in the cycle whose closing edge performs the final step.
module bin_to_bcd_seq
    import alu_disp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [8:0]  bin,
    output logic        done,
    output logic [11:0] bcd
);
    logic [8:0]  r_sh;
    logic [11:0] r_bcd;
    logic [3:0]  r_iter;
    logic [11:0] w_adj;
    assign w_adj = add3(r_bcd);
    assign done  = (r_iter == 4'(N_ITER - 1));
    assign bcd   = r_bcd;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh   <= '0;
            r_bcd  <= '0;
            r_iter <= 4'(N_ITER);
        end else if (start) begin
            r_sh   <= bin;
            r_bcd  <= '0;
            r_iter <= '0;
        end else if (r_iter < 4'(N_ITER)) begin
            {r_bcd, r_sh} <= {w_adj[10:0], r_sh, 1'b0};
            r_iter        <= r_iter + 4'd1;
        end
    end
endmodule

// File: rtl/alu_result_display.sv
// alu_result_display: captures the ALU result, converts it to BCD and scans it
// onto a 4-digit common-anode display, acking the ALU once the display updates.
module alu_result_display
    import alu_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int RES_W       = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RES_W-1:0] res_in,
    input  logic             res_valid,
    output logic             ack,
    output logic             busy,
    output logic [3:0]       an,
    output logic [6:0]       seg,
    output logic             dp
);
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    state_t          r_state, w_state_nx;
    logic            r_ack, r_busy, w_ack_nx, w_busy_nx, w_start, w_load, w_done;
    logic [11:0]     w_bcd, r_disp;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_idx;
    logic [3:0]      r_an, w_h, w_t, w_u;
    logic [6:0]      r_seg, w_seg;
    bin_to_bcd_seq u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (w_start),
        .bin   (res_in),
        .done  (w_done),
        .bcd   (w_bcd)
    );
    always_comb begin
        w_state_nx = r_state;
        w_ack_nx   = r_ack;
        w_busy_nx  = r_busy;
        w_start    = 1'b0;
        w_load     = 1'b0;
        case (r_state)
            ST_IDLE: if (res_valid) begin
                w_start    = 1'b1;
                w_busy_nx  = 1'b1;
                w_state_nx = ST_CONV;
            end
            ST_CONV: if (w_done) w_state_nx = ST_LOAD;
            ST_LOAD: begin
                w_load     = 1'b1;
                w_busy_nx  = 1'b0;
                w_ack_nx   = 1'b1;
                w_state_nx = ST_ACK;
            end
            ST_ACK: if (!res_valid) begin
                w_ack_nx   = 1'b0;
                w_state_nx = ST_IDLE;
            end
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_disp  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_ack   <= w_ack_nx;
            r_busy  <= w_busy_nx;
            if (w_load) r_disp <= w_bcd;
        end
    end
    // Free-running scan, independent of the handshake FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (r_cnt == CW'(REFRESH_DIV - 1)) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end
    assign {w_h, w_t, w_u} = r_disp;
    always_comb begin
        w_seg = (r_idx == 2'd0) ? seg_of(w_u) :
                (r_idx == 2'd1) ? ((w_h == 4'd0 && w_t == 4'd0) ? SEG_BLANK : seg_of(w_t)) :
                (r_idx == 2'd2) ? ((w_h == 4'd0) ? SEG_BLANK : seg_of(w_h)) : SEG_BLANK;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an  <= 4'b1110;
            r_seg <= SEG_0;
        end else begin
            r_an  <= ~(4'b0001 << r_idx);
            r_seg <= w_seg;
        end
    end
    assign ack  = r_ack;
    assign busy = r_busy;
    assign an   = r_an;
    assign seg  = r_seg;
    assign dp   = 1'b1;
endmodule

// File: tb/tb_alu_result_display.sv
// tb_alu_result_display: scoreboard bench for the ALU result display (REFRESH_DIV=4).
module tb_alu_result_display;
    localparam int RD = 4;
    localparam logic [6:0] SEG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       res_valid = 1'b0;
    logic [8:0] res_in = '0;
    logic       ack, busy, dp;
    logic [3:0] an;
    logic [6:0] seg;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [27:0] sb_q [$];

    alu_result_display #(.REFRESH_DIV(RD), .RES_W(9)) dut (
        .clk       (clk),
        .rst       (rst),
        .res_in    (res_in),
        .res_valid (res_valid),
        .ack       (ack),
        .busy      (busy),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [27:0] exp_disp(input int v);
        int h, t, u;
        h = v / 100;
        t = (v / 10) % 10;
        u = v % 10;
        return {7'h7F, (h == 0) ? 7'h7F : SEG_TAB[h],
                (h == 0 && t == 0) ? 7'h7F : SEG_TAB[t], SEG_TAB[u]};
    endfunction

    task automatic run_result(input logic [8:0] v, input int change_at,
                              input logic [8:0] v2, input int hold);
        int lat, busy_n, bad, onehot_bad;
        logic got_ack;
        logic [27:0] exp;
        logic [6:0] slot [4];
        @(negedge clk);
        res_in = v;
        res_valid = 1'b1;
        sb_q.push_back(exp_disp(int'(v)));
        lat = 0;
        busy_n = 0;
        got_ack = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == change_at) res_in = v2;
            if (busy) busy_n++;
            if (ack) begin
                lat = k - 1;
                got_ack = 1'b1;
                break;
            end
        end
        check($sformatf("ack_seen_%0d", v), got_ack, 1);
        exp = sb_q.pop_front();
        if (!got_ack) return;
        check($sformatf("latency_%0d", v), lat, 10);
        check($sformatf("busy_cycles_%0d", v), busy_n, 10);
        if (hold > 0) begin
            bad = 0;
            repeat (hold) begin
                @(negedge clk);
                if (!ack || busy) bad++;
            end
            check($sformatf("hold_no_reconv_%0d", v), bad, 0);
        end
        for (int j = 0; j < 4; j++) slot[j] = 7'h00;
        onehot_bad = 0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ($countones(~an) != 1) onehot_bad++;
            else for (int j = 0; j < 4; j++) if (!an[j]) slot[j] = seg;
        end
        check($sformatf("onehot_an_%0d", v), onehot_bad, 0);
        check($sformatf("digits_%0d", v), {slot[3], slot[2], slot[1], slot[0]}, exp);
        check($sformatf("dp_%0d", v), dp, 1);
        check($sformatf("ack_held_%0d", v), ack, 1);
        res_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check($sformatf("ack_drop_%0d", v), ack, 0);
    endtask

    initial begin
        int bad;
        #25;
        check("reset_an", an, 4'b1110);
        check("reset_seg", seg, 7'h40);
        check("reset_dp", dp, 1);
        check("reset_ack", ack, 0);
        check("reset_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        run_result(9'd225, 0, 9'd0, 0);
        run_result(9'd31, 0, 9'd0, 0);
        run_result(9'd0, 0, 9'd0, 0);
        run_result(9'd511, 0, 9'd0, 0);
        @(negedge clk);
        res_in = 9'd300;
        res_valid = 1'b1;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        check("mid_conv_busy", busy, 1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_an", an, 4'b1110);
        check("async_rst_seg", seg, 7'h40);
        check("async_rst_ack", ack, 0);
        check("async_rst_busy", busy, 0);
        @(negedge clk);
        res_valid = 1'b0;
        rst = 1'b0;
        bad = 0;
        repeat (15) begin
            @(negedge clk);
            if (ack || busy) bad++;
        end
        check("rst_abort_no_ack", bad, 0);
        run_result(9'd100, 3, 9'd7, 15);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
